vxe_biu_rd_mux: RTL and testbench
=================================

Name: vxe_biu_rd_mux

Overview:
Two-client read-request multiplexer directly upstream of the AXI4 master BIU read path.
- Request side: arbitrates client read requests round-robin, tags each with the client index, and queues them in an output FIFO driving the BIU pop-style request interface.
- Response side: routes BIU read responses back to the owning client by the CID MSB, propagating per-client backpressure through biu_rready.

Parameters:
ADDR_WIDTH, 32, request address width
DATA_WIDTH, 32, read data width
CID_WIDTH, 8, BIU client-id width; MSB is client index, lower CID_WIDTH-1 bits are client tag
QDEPTH_LOG2, 2, log2 of output request FIFO depth (default 4 entries)
MAX_OUTST, 8, per-client outstanding-read limit (optional feature only; 1..15)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
c0_artag  in  CID_WIDTH-1  client 0 request tag
c0_araddr  in  ADDR_WIDTH  client 0 request address
c0_arvalid  in  1  client 0 request valid
c0_arready  out  1  client 0 request accepted this cycle
c0_rtag  out  CID_WIDTH-1  client 0 response tag
c0_rdata  out  DATA_WIDTH  client 0 response data
c0_rresp  out  2  client 0 AXI response code
c0_rvalid  out  1  client 0 response valid
c0_rready  in  1  client 0 response ready
c1_*  (same set as c0_*)  client 1
biu_arcid  out  CID_WIDTH  FIFO head {client index, tag}
biu_araddr  out  ADDR_WIDTH  FIFO head address
biu_arvalid  out  1  FIFO not empty
biu_arpop  in  1  BIU pop request
biu_rcid  in  CID_WIDTH  response client id
biu_rdata  in  DATA_WIDTH  response data
biu_rresp  in  2  response code
biu_rready  out  1  ready toward BIU
biu_rpush  in  1  BIU response valid

Behaviour:
- Reset: rst async, active-high.
  - FIFO pointers cleared; biu_arvalid=0; cN_arready=0.
  - Round-robin pointer is "last granted = 1", so client 0 wins first.
  - Outstanding counters are 0.
- Output FIFO: 2^QDEPTH_LOG2 entries, pointers QDEPTH_LOG2+1 bits with wrap bit.
  - full = index equal and wrap bits differ; empty = pointers equal.
  - biu_arvalid = ~empty; biu_arcid/biu_araddr = head entry, combinational from registers.
- Pop:
  - Occurs on any edge with biu_arpop=1 and biu_arvalid=1.
  - The BIU captures the head on that same edge, and the read pointer increments.
  - biu_arpop with empty FIFO is ignored.
- Arbiter (combinational grant, registered state):
  - A grant is issued only when the FIFO is not full. Full is evaluated on registered pointers; there is no push bypass of a same-cycle pop.
  - Only one client is valid: that client is granted.
  - Both clients are valid: the client not granted last time wins.
  - cN_arready = grant_N, so at most one is high per cycle.
  - On a grant edge the entry {N, cN_artag, cN_araddr} is written, the write pointer increments, and the last-granted pointer updates.
- Request latency: a request accepted at edge T gives biu_arvalid=1 from T+ when the FIFO was empty.
- Simultaneous push and pop in the same cycle are both performed; occupancy is unchanged.
- Response routing (combinational):
  - cN_rvalid = biu_rpush & (biu_rcid[CID_WIDTH-1]==N).
  - cN_rtag = biu_rcid[CID_WIDTH-2:0]; rdata/rresp are broadcast to both clients.
  - biu_rready = ~biu_rpush | target client's cN_rready.
  - A response transfer happens on an edge with biu_rpush=1 and biu_rready=1.
  - The BIU holds rcid/rdata/rpush stable while biu_rready=0.
- Reset mid-operation: queued requests are discarded; no response state is held in this block.

Optional Feature:
VXE_BIU_RD_MUX_OUTST_EN:
- Defined:
  - Per-client 4-bit outstanding counter: +1 on accept, -1 on response transfer to that client, net 0 when both happen on the same edge.
  - A client whose counter equals MAX_OUTST is masked from arbitration (cN_arready=0).
  - The counter never underflows; a response arriving with counter 0 leaves it at 0.
- Undefined: no counters, no masking, MAX_OUTST unused.

Test Plan:
- Reset release, c0 requests addr 0x100 tag 0x05, FIFO empty -> c0_arready=1 for one cycle; next cycle biu_arvalid=1, biu_arcid=0x05, biu_araddr=0x100.
- c0 and c1 both hold valid for 4 cycles, biu_arpop=1 throughout -> grants alternate 0,1,0,1; biu_arcid MSB sequence 0,1,0,1.
- biu_arpop=0, c1 valid continuously -> exactly 4 accepts, then c1_arready=0 (full); one pop edge -> one further accept the following cycle.
- biu_rpush=1, rcid=0x83, c1_rready=0 for 3 cycles -> c1_rvalid=1, c1_rtag=0x03, biu_rready=0; c1_rready=1 -> biu_rready=1 and transfer on that edge; c0_rvalid stays 0.
- With VXE_BIU_RD_MUX_OUTST_EN and MAX_OUTST=2: c0 issues 2 requests, no responses -> c0_arready stays 0; one response to c0 -> a third request is accepted the next cycle.
- rst asserted with 3 queued entries -> biu_arvalid=0 immediately (asynchronous); after release the FIFO is empty and client 0 has priority.

Source files
------------

// File: rtl/vxe_biu_rd_mux_if.sv
// vxe_biu_rd_mux_if: client and BIU read-path bundle for the two-client read mux
// Ports: c0_*/c1_* client request/response channels, biu_ar* pop-style request
// queue head, biu_r* push-style response channel.
// master = the mux itself, slave = the clients/BIU environment.
interface vxe_biu_rd_mux_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CID_WIDTH  = 8
);
    logic [CID_WIDTH-2:0]  c0_artag;
    logic [ADDR_WIDTH-1:0] c0_araddr;
    logic                  c0_arvalid;
    logic                  c0_arready;
    logic [CID_WIDTH-2:0]  c0_rtag;
    logic [DATA_WIDTH-1:0] c0_rdata;
    logic [1:0]            c0_rresp;
    logic                  c0_rvalid;
    logic                  c0_rready;
    logic [CID_WIDTH-2:0]  c1_artag;
    logic [ADDR_WIDTH-1:0] c1_araddr;
    logic                  c1_arvalid;
    logic                  c1_arready;
    logic [CID_WIDTH-2:0]  c1_rtag;
    logic [DATA_WIDTH-1:0] c1_rdata;
    logic [1:0]            c1_rresp;
    logic                  c1_rvalid;
    logic                  c1_rready;
    logic [CID_WIDTH-1:0]  biu_arcid;
    logic [ADDR_WIDTH-1:0] biu_araddr;
    logic                  biu_arvalid;
    logic                  biu_arpop;
    logic [CID_WIDTH-1:0]  biu_rcid;
    logic [DATA_WIDTH-1:0] biu_rdata;
    logic [1:0]            biu_rresp;
    logic                  biu_rready;
    logic                  biu_rpush;

    modport master (
        input  c0_artag, c0_araddr, c0_arvalid, c0_rready,
        input  c1_artag, c1_araddr, c1_arvalid, c1_rready,
        input  biu_arpop, biu_rcid, biu_rdata, biu_rresp, biu_rpush,
        output c0_arready, c0_rtag, c0_rdata, c0_rresp, c0_rvalid,
        output c1_arready, c1_rtag, c1_rdata, c1_rresp, c1_rvalid,
        output biu_arcid, biu_araddr, biu_arvalid, biu_rready
    );

    modport slave (
        output c0_artag, c0_araddr, c0_arvalid, c0_rready,
        output c1_artag, c1_araddr, c1_arvalid, c1_rready,
        output biu_arpop, biu_rcid, biu_rdata, biu_rresp, biu_rpush,
        input  c0_arready, c0_rtag, c0_rdata, c0_rresp, c0_rvalid,
        input  c1_arready, c1_rtag, c1_rdata, c1_rresp, c1_rvalid,
        input  biu_arcid, biu_araddr, biu_arvalid, biu_rready
    );
endinterface

// File: rtl/vxe_biu_rd_mux.sv
// vxe_biu_rd_mux: round-robin two-client read-request mux with request FIFO and response router
// Ports: clk, rst (async active-high), bus (vxe_biu_rd_mux_if.master) carrying
// the c0_*/c1_* client channels and the biu_ar*/biu_r* BIU channels.
// Optional: define VXE_BIU_RD_MUX_OUTST_EN to add per-client outstanding-read
// counters that mask a client from arbitration once it reaches MAX_OUTST.
module vxe_biu_rd_mux #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int CID_WIDTH   = 8,
    parameter int QDEPTH_LOG2 = 2,
    parameter int MAX_OUTST   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    vxe_biu_rd_mux_if.master      bus
);
    localparam int QD = 1 << QDEPTH_LOG2;

    logic [QDEPTH_LOG2:0]  wr_ptr, rd_ptr;
    logic [CID_WIDTH-1:0]  q_cid  [QD];
    logic [ADDR_WIDTH-1:0] q_addr [QD];
    logic last_gnt, full, empty, elig0, elig1, gnt0, gnt1, push, pop, r_client, rready;

    assign full  = (wr_ptr[QDEPTH_LOG2-1:0] == rd_ptr[QDEPTH_LOG2-1:0]) &&
                   (wr_ptr[QDEPTH_LOG2] != rd_ptr[QDEPTH_LOG2]);
    assign empty = wr_ptr == rd_ptr;

    // last_gnt=1 means client 1 won last, so client 0 has priority on a tie.
    // Grants are held off during reset so arready stays low while rst is high.
    assign gnt0 = ~rst & ~full & elig0 & (~elig1 | last_gnt);
    assign gnt1 = ~rst & ~full & elig1 & (~elig0 | ~last_gnt);
    assign push = gnt0 | gnt1;
    assign pop  = bus.biu_arpop & ~empty;

    assign bus.c0_arready  = gnt0;
    assign bus.c1_arready  = gnt1;
    assign bus.biu_arvalid = ~empty;
    assign bus.biu_arcid   = q_cid[rd_ptr[QDEPTH_LOG2-1:0]];
    assign bus.biu_araddr  = q_addr[rd_ptr[QDEPTH_LOG2-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            q_cid[wr_ptr[QDEPTH_LOG2-1:0]]  <= gnt1 ? {1'b1, bus.c1_artag} : {1'b0, bus.c0_artag};
            q_addr[wr_ptr[QDEPTH_LOG2-1:0]] <= gnt1 ? bus.c1_araddr : bus.c0_araddr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            last_gnt <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push) last_gnt <= gnt1;
        end
    end

    // Responses are steered by the client-index MSB of the CID; only the
    // addressed client's ready gates the BIU.
    assign r_client       = bus.biu_rcid[CID_WIDTH-1];
    assign rready         = ~bus.biu_rpush | (r_client ? bus.c1_rready : bus.c0_rready);
    assign bus.biu_rready = rready;
    assign bus.c0_rvalid  = bus.biu_rpush & ~r_client;
    assign bus.c1_rvalid  = bus.biu_rpush & r_client;
    assign bus.c0_rtag    = bus.biu_rcid[CID_WIDTH-2:0];
    assign bus.c1_rtag    = bus.biu_rcid[CID_WIDTH-2:0];
    assign bus.c0_rdata   = bus.biu_rdata;
    assign bus.c1_rdata   = bus.biu_rdata;
    assign bus.c0_rresp   = bus.biu_rresp;
    assign bus.c1_rresp   = bus.biu_rresp;

`ifdef VXE_BIU_RD_MUX_OUTST_EN
    logic [3:0] cnt0, cnt1;
    logic xfer0, xfer1;

    assign xfer0 = bus.biu_rpush & rready & ~r_client;
    assign xfer1 = bus.biu_rpush & rready & r_client;
    assign elig0 = bus.c0_arvalid & (cnt0 != 4'(MAX_OUTST));
    assign elig1 = bus.c1_arvalid & (cnt1 != 4'(MAX_OUTST));

    // Accept and response on the same edge cancel; a stray response at zero is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            cnt0 <= (gnt0 & ~xfer0) ? cnt0 + 4'd1 : (xfer0 & ~gnt0 & (cnt0 != 0)) ? cnt0 - 4'd1 : cnt0;
            cnt1 <= (gnt1 & ~xfer1) ? cnt1 + 4'd1 : (xfer1 & ~gnt1 & (cnt1 != 0)) ? cnt1 - 4'd1 : cnt1;
        end
    end
`else
    logic unused_max_outst;

    assign elig0            = bus.c0_arvalid;
    assign elig1            = bus.c1_arvalid;
    assign unused_max_outst = ^MAX_OUTST;
`endif
endmodule

// File: tb/tb_vxe_biu_rd_mux.sv
// tb_vxe_biu_rd_mux: directed self-checking bench for vxe_biu_rd_mux
module tb_vxe_biu_rd_mux;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int n_chk = 0;
    int n_err = 0;

`ifdef VXE_BIU_RD_MUX_OUTST_EN
    localparam logic [6:0] SC5_EXP = 7'b0100011;
`else
    localparam logic [6:0] SC5_EXP = 7'b1111111;
`endif

    vxe_biu_rd_mux_if bus ();

    vxe_biu_rd_mux #(.MAX_OUTST(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        bus.c0_artag = '0; bus.c0_araddr = '0; bus.c0_arvalid = 0; bus.c0_rready = 0;
        bus.c1_artag = '0; bus.c1_araddr = '0; bus.c1_arvalid = 0; bus.c1_rready = 0;
        bus.biu_arpop = 0; bus.biu_rcid = '0; bus.biu_rdata = '0; bus.biu_rresp = '0; bus.biu_rpush = 0;
        #1 rst = 1'b1;
        bus.c0_arvalid = 1;
        #1;
        chk("rst_arvalid", bus.biu_arvalid, 0);
        chk("rst_c0_arready", bus.c0_arready, 0);
        // first request after reset
        @(negedge clk);
        rst = 0; bus.c0_artag = 7'h05; bus.c0_araddr = 32'h100; bus.c0_arvalid = 1;
        #1;
        chk("sc1_c0_arready", bus.c0_arready, 1);
        chk("sc1_empty", bus.biu_arvalid, 0);
        @(negedge clk);
        bus.c0_arvalid = 0; bus.biu_arpop = 1;
        #1;
        chk("sc1_arready_drop", bus.c0_arready, 0);
        chk("sc1_arvalid", bus.biu_arvalid, 1);
        chk("sc1_arcid", bus.biu_arcid, 8'h05);
        chk("sc1_araddr", bus.biu_araddr, 32'h100);
        @(negedge clk);
        bus.biu_arpop = 0;
        #1;
        chk("sc1_popped", bus.biu_arvalid, 0);
        // fill to full with both clients, no pops
        do_reset();
        bus.c0_artag = 7'h0A; bus.c1_artag = 7'h0B;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.c0_arvalid = 1; bus.c1_arvalid = 1;
            bus.c0_araddr = 32'h200 + i * 8; bus.c1_araddr = 32'h204 + i * 8;
            #1;
            chk("sc3_c0_grant", bus.c0_arready, (i % 2) == 0);
            chk("sc3_c1_grant", bus.c1_arready, (i % 2) == 1);
        end
        @(negedge clk);
        #1;
        chk("sc3_full_c0", bus.c0_arready, 0);
        chk("sc3_full_c1", bus.c1_arready, 0);
        chk("sc3_head_cid", bus.biu_arcid, 8'h0A);
        chk("sc3_head_addr", bus.biu_araddr, 32'h200);
        @(negedge clk);
        bus.biu_arpop = 1; bus.biu_rpush = 1; bus.biu_rcid = 8'h01; bus.c0_rready = 1;
        #1;
        chk("sc3_nobypass_c0", bus.c0_arready, 0);
        chk("sc3_nobypass_c1", bus.c1_arready, 0);
        chk("sc3_rready", bus.biu_rready, 1);
        @(negedge clk);
        bus.biu_arpop = 0; bus.biu_rpush = 0; bus.c0_araddr = 32'h240;
        #1;
        chk("sc3_refill_c0", bus.c0_arready, 1);
        chk("sc3_refill_c1", bus.c1_arready, 0);
        chk("sc3_head2_cid", bus.biu_arcid, 8'h8B);
        chk("sc3_head2_addr", bus.biu_araddr, 32'h20C);
        @(negedge clk);
        #1;
        chk("sc3_full2", {bus.c0_arready, bus.c1_arready}, 2'b00);
        @(negedge clk);
        bus.c0_arvalid = 0; bus.c1_arvalid = 0; bus.biu_arpop = 1;
        @(negedge clk);
        bus.biu_arpop = 0;
        #1;
        chk("sc6_head_cid", bus.biu_arcid, 8'h0A);
        chk("sc6_head_addr", bus.biu_araddr, 32'h210);
        chk("sc6_queued", bus.biu_arvalid, 1);
        // asynchronous reset with three entries queued
        #2 rst = 1;
        #1;
        chk("sc6_async_clear", bus.biu_arvalid, 0);
        @(negedge clk);
        rst = 0;
        #1;
        chk("sc6_after_rst", bus.biu_arvalid, 0);
        // alternating grants with continuous pop
        bus.c0_artag = 7'h0A; bus.c0_araddr = 32'h300; bus.c1_artag = 7'h0B; bus.c1_araddr = 32'h400;
        bus.biu_arpop = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.c0_arvalid = 1; bus.c1_arvalid = 1;
            #1;
            chk("sc2_c0_grant", bus.c0_arready, (i % 2) == 0);
            chk("sc2_c1_grant", bus.c1_arready, (i % 2) == 1);
            if (i > 0) chk("sc2_head_msb", bus.biu_arcid[7], ((i - 1) % 2) == 1);
            else chk("sc2_first_empty", bus.biu_arvalid, 0);
        end
        @(negedge clk);
        bus.c0_arvalid = 0; bus.c1_arvalid = 0;
        #1;
        chk("sc2_last_msb", bus.biu_arcid[7], 1);
        chk("sc2_occupancy", bus.biu_arvalid, 1);
        @(negedge clk);
        bus.biu_arpop = 0;
        #1;
        chk("sc2_drained", bus.biu_arvalid, 0);
        // response routing with backpressure
        @(negedge clk);
        bus.biu_rpush = 1; bus.biu_rcid = 8'h83; bus.biu_rdata = 32'hDEADBEEF; bus.biu_rresp = 2'd2;
        bus.c1_rready = 0; bus.c0_rready = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("sc4_c1_rvalid", bus.c1_rvalid, 1);
            chk("sc4_c1_rtag", bus.c1_rtag, 7'h03);
            chk("sc4_rready_low", bus.biu_rready, 0);
            chk("sc4_c0_rvalid", bus.c0_rvalid, 0);
            @(negedge clk);
        end
        bus.c1_rready = 1;
        #1;
        chk("sc4_rready_high", bus.biu_rready, 1);
        chk("sc4_c1_rdata", bus.c1_rdata, 32'hDEADBEEF);
        chk("sc4_c1_rresp", bus.c1_rresp, 2'd2);
        chk("sc4_c0_quiet", bus.c0_rvalid, 0);
        @(negedge clk);
        bus.biu_rcid = 8'h07; bus.c0_rready = 0; bus.biu_rdata = 32'h12345678;
        #1;
        chk("sc4_c0_rvalid", bus.c0_rvalid, 1);
        chk("sc4_c0_rtag", bus.c0_rtag, 7'h07);
        chk("sc4_c0_rdata", bus.c0_rdata, 32'h12345678);
        chk("sc4_c1_quiet", bus.c1_rvalid, 0);
        chk("sc4_c0_bp", bus.biu_rready, 0);
        @(negedge clk);
        bus.biu_rpush = 0;
        #1;
        chk("sc4_idle_rready", bus.biu_rready, 1);
        chk("sc4_idle_rvalid", bus.c0_rvalid, 0);
        // outstanding limit (unlimited in the default build)
        do_reset();
        bus.c0_artag = 7'h01; bus.c0_araddr = 32'h500; bus.biu_arpop = 1; bus.c0_rready = 1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            bus.c0_arvalid = 1; bus.biu_rpush = (i == 4); bus.biu_rcid = 8'h00;
            #1;
            chk("sc5_c0_arready", bus.c0_arready, SC5_EXP[i]);
        end
        @(negedge clk);
        bus.c0_arvalid = 0; bus.biu_rpush = 0; bus.biu_arpop = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
